// File: rtl/dwt_pkg.sv
// dwt_pkg: DB6 decomposition filter constants (Q1.15) and shared types for the DWT core
package dwt_pkg;
  localparam int pWIDTH = 16;
  localparam int DWT_TAPS = 12;
  typedef logic signed [pWIDTH-1:0] coef_t;
  localparam coef_t pDB6_Lo_D [DWT_TAPS] = '{
    -16'sd35, 16'sd157, 16'sd18, -16'sd1035, 16'sd902, 16'sd3195,
    -16'sd4252, -16'sd7414, 16'sd10330, 16'sd24613, 16'sd16208, 16'sd3655
  };
  // Hi_D[k] = (-1)^(k+1) * Lo_D[11-k]
  localparam coef_t pDB6_Hi_D [DWT_TAPS] = '{
    -16'sd3655, 16'sd16208, -16'sd24613, 16'sd10330, 16'sd7414, -16'sd4252,
    -16'sd3195, 16'sd902, 16'sd1035, 16'sd18, -16'sd157, -16'sd35
  };
endpackage

// File: rtl/dwt_mac.sv
// dwt_mac: signed multiply-accumulate with synchronous clear and enable
module dwt_mac #(
  parameter int pWIDTH = 16
) (
  input  logic                       iclk,
  input  logic                       irst,
  input  logic                       clr,
  input  logic                       en,
  input  logic signed [pWIDTH-1:0]   a,
  input  logic signed [pWIDTH-1:0]   b,
  output logic signed [2*pWIDTH+3:0] acc
);
  logic signed [2*pWIDTH-1:0] prod;
  assign prod = a * b;
  always_ff @(posedge iclk or negedge irst)
    if (!irst) acc <= '0;
    else acc <= clr ? '0 : en ? acc + (2*pWIDTH+4)'(prod) : acc;
endmodule

// File: rtl/dwt_core_l1.sv
// dwt_core_l1: one-level DB6 analysis (L/H, decimate by 2) with a 12-cycle sequential MAC.
// Define DWT_OUT_SAT_EN to clamp results to the output range instead of wrapping.
module dwt_core_l1 #(
  parameter int pWIDTH = dwt_pkg::pWIDTH
) (
  input  logic                       iclk,
  input  logic                       irst,
  input  logic                       iclk_ena,
  input  logic                       iclk_enax2,
  input  logic signed [pWIDTH-1:0]   idat,
  input  logic                       iena,
  output logic                       oena,
  output logic signed [2*pWIDTH-1:0] odatH,
  output logic signed [2*pWIDTH-1:0] odatL
);
  import dwt_pkg::*;
  localparam int OW = 2*pWIDTH;
  localparam int AW = OW + 4;
  localparam logic [3:0] LAST = 4'(DWT_TAPS - 1);
  logic signed [pWIDTH-1:0] dl [DWT_TAPS];
  logic signed [pWIDTH-1:0] dl_nx [DWT_TAPS];
  logic signed [pWIDTH-1:0] snap [DWT_TAPS];
  logic signed [AW-1:0] acc_l, acc_h;
  logic [3:0] tap;
  logic accept, pair, flag, busy;
  assign accept = iclk_enax2 & iena;
  always_comb begin
    dl_nx[0] = accept ? idat : dl[0];
    for (int i = 1; i < DWT_TAPS; i++) dl_nx[i] = accept ? dl[i-1] : dl[i];
  end
`ifdef DWT_OUT_SAT_EN
  localparam logic signed [OW-1:0] OMAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] OMIN = {1'b1, {(OW-1){1'b0}}};
  function automatic logic signed [OW-1:0] fit(input logic signed [AW-1:0] a);
    return a > AW'(OMAX) ? OMAX : a < AW'(OMIN) ? OMIN : OW'(a);
  endfunction
`else
  function automatic logic signed [OW-1:0] fit(input logic signed [AW-1:0] a);
    return OW'(a);
  endfunction
`endif
  // pair marks one sample taken since the last snapshot; a second one at the snapshot completes the pair
  always_ff @(posedge iclk or negedge irst)
    if (!irst) begin
      dl <= '{default: '0};
      snap <= '{default: '0};
      pair <= 1'b0;
      flag <= 1'b0;
      busy <= 1'b0;
      tap <= '0;
      oena <= 1'b0;
      odatL <= '0;
      odatH <= '0;
    end else begin
      dl <= dl_nx;
      pair <= iclk_ena ? 1'b0 : pair ^ accept;
      if (iclk_ena) begin
        snap <= dl_nx;
        flag <= pair & accept;
        busy <= 1'b1;
        tap <= '0;
        oena <= flag;
        odatL <= flag ? fit(acc_l) : odatL;
        odatH <= flag ? fit(acc_h) : odatH;
      end else if (busy) begin
        busy <= tap != LAST;
        tap <= tap == LAST ? tap : tap + 4'd1;
      end
    end
  dwt_mac #(.pWIDTH(pWIDTH)) u_mac_l (
    .iclk(iclk), .irst(irst), .clr(iclk_ena), .en(busy),
    .a(snap[tap]), .b(pDB6_Lo_D[tap]), .acc(acc_l)
  );
  dwt_mac #(.pWIDTH(pWIDTH)) u_mac_h (
    .iclk(iclk), .irst(irst), .clr(iclk_ena), .en(busy),
    .a(snap[tap]), .b(pDB6_Hi_D[tap]), .acc(acc_h)
  );
endmodule

// File: tb/tb_dwt_core_l1.sv
// tb_dwt_core_l1: directed stimulus against a convolution model of the DB6 analysis stage
module tb_dwt_core_l1;
  logic iclk = 1'b0, irst = 1'b1, iclk_ena = 1'b0, iclk_enax2 = 1'b0, iena = 1'b0;
  logic signed [15:0] idat = '0;
  logic oena;
  logic signed [31:0] odatH, odatL;
  dwt_core_l1 #(.pWIDTH(16)) dut (
    .iclk(iclk), .irst(irst), .iclk_ena(iclk_ena), .iclk_enax2(iclk_enax2),
    .idat(idat), .iena(iena), .oena(oena), .odatH(odatH), .odatL(odatL)
  );
  always #5 iclk = ~iclk;
  localparam int LO [12] = '{-35, 157, 18, -1035, 902, 3195, -4252, -7414, 10330, 24613, 16208, 3655};
  int n_chk = 0, n_fail = 0;
  bit run = 0, phase = 0;
  int hist [12];
  int cnt;
  bit m_flag;
  longint m_l, m_h;
  logic exp_oena;
  logic signed [31:0] exp_l, exp_h;

  function automatic int hi(input int k);
    return (k % 2 == 1) ? LO[11-k] : -LO[11-k];
  endfunction

  function automatic logic signed [31:0] fit(input longint v);
`ifdef DWT_OUT_SAT_EN
    if (v > 64'sd2147483647) return 32'sh7fffffff;
    if (v < -64'sd2147483648) return 32'sh80000000;
`endif
    return 32'(v);
  endfunction

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, req);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 12; k++) hist[k] = 0;
    cnt = 0;
    m_flag = 0;
    m_l = 0;
    m_h = 0;
    exp_oena = 1'b0;
    exp_l = '0;
    exp_h = '0;
  endtask

  // one output per snapshot: 12-tap convolution of the newest accepted samples, shown one period later
  task automatic model(input bit v, input int d, input bit e);
    if (v) begin
      for (int k = 11; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = d;
      cnt++;
    end
    if (e) begin
      exp_oena = m_flag;
      if (m_flag) begin
        exp_l = fit(m_l);
        exp_h = fit(m_h);
      end
      m_l = 0;
      m_h = 0;
      for (int k = 0; k < 12; k++) begin
        m_l += longint'(LO[k]) * longint'(hist[k]);
        m_h += longint'(hi(k)) * longint'(hist[k]);
      end
      m_flag = (cnt == 2);
      cnt = 0;
    end
  endtask

  always @(negedge iclk) if (run) begin
    chk("oena", oena, exp_oena);
    chk("odatL", odatL, exp_l);
    chk("odatH", odatH, exp_h);
  end

  task automatic strobe(input bit v, input int d);
    @(negedge iclk);
    iclk_enax2 = 1'b1;
    iclk_ena = phase;
    iena = v;
    idat = 16'(d);
    @(posedge iclk);
    #1;
    model(v, d, phase);
    iclk_enax2 = 1'b0;
    iclk_ena = 1'b0;
    iena = 1'b0;
    phase = ~phase;
    repeat (7) @(posedge iclk);
  endtask

  task automatic pulse_reset();
    #2 irst = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_oena", oena, 0);
    chk("rst_mid_odatL", odatL, 0);
    chk("rst_mid_odatH", odatH, 0);
    repeat (3) @(negedge iclk);
    irst = 1'b1;
    phase = 0;
  endtask

  initial begin
    model_reset();
    #1 irst = 1'b0;
    run = 1;
    repeat (2) @(negedge iclk);
    chk("reset_oena", oena, 0);
    chk("reset_odatL", odatL, 0);
    chk("reset_odatH", odatH, 0);
    irst = 1'b1;
    strobe(1, 16384);
    for (int i = 1; i <= 20; i++) begin
      strobe(1, 0);
      if (i == 3) begin
        chk("imp_L1", odatL, 2572288);
        chk("imp_H1", odatH, 265551872);
      end
      if (i == 5) begin
        chk("imp_L3", odatL, -16957440);
        chk("imp_H3", odatH, 169246720);
      end
    end
    for (int i = 0; i < 40; i++) strobe(1, 1000);
    chk("dc_L", odatL, 46342000);
    chk("dc_H", odatH, 0);
    for (int i = 0; i < 40; i++) strobe(1, (i % 2 == 1) ? -1000 : 1000);
    chk("alt_L", odatL, 0);
    chk("alt_absH", (odatH < 0) ? -odatH : odatH, 46342000);
    for (int i = 0; i < 10; i++) strobe(1, i * 37 - 200);
    for (int i = 0; i < 3; i++) strobe(0, 12345);
    for (int i = 0; i < 12; i++) strobe(1, 900 - i * 113);
    if (!phase) strobe(1, 500);
    strobe(1, 700);
    pulse_reset();
    strobe(1, 100);
    strobe(1, 200);
    strobe(1, 300);
    strobe(1, 400);
    chk("post_rst_L", odatL, 8700);
    chk("post_rst_H", odatH, 889800);
    for (int i = 0; i < 30; i++) strobe(1, (i % 2 == 1) ? 32767 : -32768);
    strobe(1, 0);
    strobe(1, 0);
    run = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
